// File: rtl/indec_with_delim_1_18_8_if.sv
// rtl/indec_with_delim_1_18_8_if.sv - call handshake and received-byte strobe bundle for the decimal parser
interface indec_with_delim_1_18_8_if #(parameter int W = 18);
  logic         start;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic [W-1:0] result;
  logic [7:0]   delim;
  logic [2:0]   digit_count;
  logic         overflow;
  logic         result_ready;

  modport master (
    output start, in_byte, in_valid,
    input  result, delim, digit_count, overflow, result_ready
  );

  modport slave (
    input  start, in_byte, in_valid,
    output result, delim, digit_count, overflow, result_ready
  );
endinterface

// File: rtl/indec_with_delim_1_18_8.sv
// rtl/indec_with_delim_1_18_8.sv - parses a delimited unsigned decimal number from a byte strobe stream
module indec_with_delim_1_18_8 #(
  parameter int W      = 18,
  parameter int MAXVAL = 262143
) (
  input  logic                clk,
  input  logic                reset_n,
  indec_with_delim_1_18_8_if.slave bus
);

  typedef enum logic [1:0] {st_ready, st_skip, st_digits} state_t;

  localparam int XW = W + 4;
  localparam logic [XW-1:0] MAX_EXT = XW'(MAXVAL);
  localparam logic [W-1:0]  MAX_W   = W'(MAXVAL);

  state_t        state;
  logic [W-1:0]  acc;
  logic [2:0]    cnt;
  logic          ovf;

  logic          is_digit;
  logic          is_ws;
  logic [3:0]    d;
  logic [XW-1:0] acc_ext;
  logic [XW-1:0] next_val;
  logic [2:0]    cnt_inc;

  // Byte classification and the shift-add times-ten step; the extra 4 bits hold MAXVAL*10+9.
  always_comb begin
    is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
    is_ws    = (bus.in_byte == 8'h20) || (bus.in_byte == 8'h09) ||
               (bus.in_byte == 8'h0D) || (bus.in_byte == 8'h0A);
    d        = bus.in_byte[3:0];
    acc_ext  = {4'd0, acc};
    next_val = (acc_ext << 3) + (acc_ext << 1) + {{(XW-4){1'b0}}, d};
    cnt_inc  = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
  end

  // Ready drops in the very cycle a call is made, so callers see the handshake immediately.
  assign bus.result_ready = (state == st_ready) && !bus.start;

  // Parse FSM; visible outputs change only when a delimiter ends the number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= st_ready;
      acc             <= '0;
      cnt             <= '0;
      ovf             <= 1'b0;
      bus.result      <= '0;
      bus.delim       <= '0;
      bus.digit_count <= '0;
      bus.overflow    <= 1'b0;
    end else if (bus.start) begin
      state <= st_skip;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (bus.in_valid) begin
      case (state)
        st_skip: begin
          if (is_digit) begin
            acc   <= {{(W-4){1'b0}}, d};
            cnt   <= 3'd1;
            state <= st_digits;
          end else if (!is_ws) begin
            bus.result      <= '0;
            bus.delim       <= bus.in_byte;
            bus.digit_count <= '0;
            bus.overflow    <= 1'b0;
            state           <= st_ready;
          end
        end
        st_digits: begin
          if (is_digit) begin
            // Once clamped, every further digit overflows again and keeps acc at MAXVAL.
            if (next_val > MAX_EXT) begin
              acc <= MAX_W;
              ovf <= 1'b1;
            end else begin
              acc <= next_val[W-1:0];
            end
            cnt <= cnt_inc;
          end else begin
            bus.result      <= acc;
            bus.delim       <= bus.in_byte;
            bus.digit_count <= cnt;
            bus.overflow    <= ovf;
            state           <= st_ready;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_indec_with_delim_1_18_8.sv
// tb/tb_indec_with_delim_1_18_8.sv - self-checking bench for the delimited decimal parser
module tb_indec_with_delim_1_18_8;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  indec_with_delim_1_18_8_if #(.W(18)) bus ();

  indec_with_delim_1_18_8 #(.W(18), .MAXVAL(262143)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: read the text left to right as a person would, with arbitrary-width arithmetic.
  function automatic void model(input bq_t q, output logic [17:0] res, output logic [7:0] dl,
                                output logic [2:0] cnt, output logic ov, output bit done);
    bit     in_num;
    longint val;
    int     n;
    logic [7:0] b;
    in_num = 0; val = 0; n = 0;
    res = '0; dl = '0; cnt = '0; ov = 1'b0; done = 0;
    for (int i = 0; i < q.size() && !done; i++) begin
      b = q[i];
      if (b >= "0" && b <= "9") begin
        val = val * 10 + (b - 8'h30);
        if (val > 262143) begin val = 262143; ov = 1'b1; end
        n++;
        in_num = 1;
      end else if (!in_num && (b == 8'h20 || b == 8'h09 || b == 8'h0D || b == 8'h0A)) begin
      end else begin
        res  = in_num ? val[17:0] : 18'd0;
        dl   = b;
        done = 1;
      end
    end
    cnt = (n > 7) ? 3'd7 : n[2:0];
  endfunction

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    vectors++;
    if (bus.result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_drop_on_start: got %b want 0", bus.result_ready);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Ends on the negedge one cycle after the last strobe was captured.
  task automatic feed(input bq_t q, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      bus.in_byte  = q[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i != q.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_byte = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
        {18'd0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got r=%0d d=%h c=%0d o=%b rdy=%b want 0 00 0 0 1",
               bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready);
    end
  endtask

  task automatic test_spaced();
    do_start();
    feed(str2q("1234"), 2);
    repeat (2) @(negedge clk);
    bus.in_byte = 8'h0D; bus.in_valid = 1'b1;
    #1;
    vectors++;
    if (bus.result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL spaced_ready_early: got %b want 0", bus.result_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
        {18'd1234, 8'h0D, 3'd4, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL spaced_1234: got r=%0d d=%h c=%0d o=%b rdy=%b want 1234 0d 4 0 1",
               bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    feed(str2q("  007,"), 0);
    vectors++;
    if ({bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
        {18'd7, 8'h2C, 3'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_007: got r=%0d d=%h c=%0d o=%b rdy=%b want 7 2c 3 0 1",
               bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready);
    end
  endtask

  task automatic test_boundary();
    do_start();
    feed(str2q("262143 "), 1);
    vectors++;
    if ({bus.result, bus.overflow, bus.digit_count} !== {18'd262143, 1'b0, 3'd6}) begin
      miscompares++;
      $display("FAIL max_exact: got r=%0d o=%b c=%0d want 262143 0 6",
               bus.result, bus.overflow, bus.digit_count);
    end
    do_start();
    feed(str2q("262144 "), 0);
    vectors++;
    if ({bus.result, bus.overflow, bus.delim} !== {18'd262143, 1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL max_plus1: got r=%0d o=%b d=%h want 262143 1 20",
               bus.result, bus.overflow, bus.delim);
    end
    do_start();
    feed(str2q("9999999x"), 0);
    vectors++;
    if ({bus.result, bus.overflow, bus.digit_count, bus.delim} !== {18'd262143, 1'b1, 3'd7, 8'h78}) begin
      miscompares++;
      $display("FAIL sat_count: got r=%0d o=%b c=%0d d=%h want 262143 1 7 78",
               bus.result, bus.overflow, bus.digit_count, bus.delim);
    end
  endtask

  task automatic test_nondigit();
    do_start();
    bus.in_valid = 1'b1; bus.in_byte = 8'h33;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.result, bus.overflow, bus.digit_count, bus.delim, bus.result_ready} !==
        {18'd262143, 1'b1, 3'd7, 8'h78, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_during_parse: got r=%0d o=%b c=%0d d=%h rdy=%b want 262143 1 7 78 0",
               bus.result, bus.overflow, bus.digit_count, bus.delim, bus.result_ready);
    end
    do_start();
    feed(str2q("A"), 0);
    vectors++;
    if ({bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
        {18'd0, 8'h41, 3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL nondigit_A: got r=%0d d=%h c=%0d o=%b rdy=%b want 0 41 0 0 1",
               bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready);
    end
    feed(str2q("9;"), 0);
    vectors++;
    if ({bus.result, bus.delim, bus.result_ready} !== {18'd0, 8'h41, 1'b1}) begin
      miscompares++;
      $display("FAIL ignore_when_ready: got r=%0d d=%h rdy=%b want 0 41 1",
               bus.result, bus.delim, bus.result_ready);
    end
  endtask

  task automatic test_restart();
    do_start();
    feed(str2q("12"), 0);
    do_start();
    feed(str2q("5;"), 0);
    vectors++;
    if ({bus.result, bus.digit_count, bus.delim, bus.overflow} !== {18'd5, 3'd1, 8'h3B, 1'b0}) begin
      miscompares++;
      $display("FAIL restart: got r=%0d c=%0d d=%h o=%b want 5 1 3b 0",
               bus.result, bus.digit_count, bus.delim, bus.overflow);
    end
  endtask

  task automatic test_reset_midparse();
    do_start();
    feed(str2q("12"), 0);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
        {18'd0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_midparse: got r=%0d d=%h c=%0d o=%b rdy=%b want 0 00 0 0 1",
               bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_start();
    feed(str2q("5;"), 0);
    vectors++;
    if ({bus.result, bus.digit_count, bus.delim} !== {18'd5, 3'd1, 8'h3B}) begin
      miscompares++;
      $display("FAIL after_reset_parse: got r=%0d c=%0d d=%h want 5 1 3b",
               bus.result, bus.digit_count, bus.delim);
    end
  endtask

  task automatic test_random();
    bq_t q;
    logic [17:0] er;
    logic [7:0]  ed, b;
    logic [2:0]  ec;
    logic        eo;
    bit          done;
    int          nd;
    for (int t = 0; t < 40; t++) begin
      q = {};
      repeat ($urandom_range(0, 2)) q.push_back(($urandom_range(0, 1) == 0) ? 8'h20 : 8'h09);
      nd = $urandom_range(0, 9);
      for (int i = 0; i < nd; i++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      do b = 8'($urandom_range(0, 255)); while (b >= 8'h30 && b <= 8'h39);
      if (nd == 0 && (b == 8'h20 || b == 8'h09 || b == 8'h0D || b == 8'h0A)) b = 8'h3B;
      q.push_back(b);
      model(q, er, ed, ec, eo, done);
      do_start();
      feed(q, $urandom_range(0, 2));
      vectors++;
      if (!done || {bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready} !==
                   {er, ed, ec, eo, 1'b1}) begin
        miscompares++;
        $display("FAIL random_%0d: got r=%0d d=%h c=%0d o=%b rdy=%b want %0d %h %0d %b 1",
                 t, bus.result, bus.delim, bus.digit_count, bus.overflow, bus.result_ready,
                 er, ed, ec, eo);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_spaced();
    test_back_to_back();
    test_boundary();
    test_nondigit();
    test_restart();
    test_reset_midparse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
